// File: rtl/johnson_phase_decoder.sv
// Decodes a twisted-ring (Johnson) counter state into a phase index and a one-hot strobe.
// Tracks phase progression and reports illegal codes and bad steps, with a lock indication.
module johnson_phase_decoder #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 3,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [WIDTH-1:0]           jc_in,
  output logic [$clog2(2*WIDTH)-1:0] phase_idx,
  output logic [2*WIDTH-1:0]         phase_onehot,
  output logic                       valid_code,
  output logic                       locked,
  output logic                       err_pulse,
  output logic                       wrap_pulse,
  output logic [ERR_CNT_W-1:0]       err_count
);

  localparam int NP = 2 * WIDTH;
  localparam int PW = $clog2(NP);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Returns {legal, phase}: MSB-aligned runs map to 0..WIDTH, LSB-aligned runs to NP-m.
  function automatic logic [PW:0] decode_jc(input logic [WIDTH-1:0] code);
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] pat;
    logic [PW:0]      res;
    ones = {WIDTH{1'b1}};
    res  = {(PW+1){1'b0}};
    for (int m = 0; m <= WIDTH; m++) begin
      pat = ~(ones >> m);
      if (code == pat) begin
        res = {1'b1, PW'(m)};
      end
    end
    for (int m = 1; m < WIDTH; m++) begin
      pat = ones >> (WIDTH - m);
      if (code == pat) begin
        res = {1'b1, PW'(NP - m)};
      end
    end
    return res;
  endfunction

  state_t          state_r;
  state_t          state_nxt_s;
  logic [7:0]      cnt_r;
  logic [7:0]      cnt_nxt_s;
  logic [PW-1:0]   prev_phase_r;
  logic [PW-1:0]   prev_phase_nxt_s;
  logic            err_nxt_s;
  logic            wrap_nxt_s;

  logic [PW:0]     dec_s;
  logic            dec_legal_s;
  logic [PW-1:0]   dec_phase_s;
  logic [PW-1:0]   exp_phase_s;
  logic            is_step_s;
  logic            is_stall_s;

  logic [PW-1:0]        idx_nxt_s;
  logic [NP-1:0]        onehot_nxt_s;
  logic                 valid_nxt_s;
  logic [ERR_CNT_W-1:0] err_count_nxt_s;

  // Decode the sample and classify it against the stored phase.
  always_comb begin
    dec_s       = decode_jc(jc_in);
    dec_legal_s = dec_s[PW];
    dec_phase_s = dec_s[PW-1:0];
    if (prev_phase_r == PW'(NP - 1)) begin
      exp_phase_s = {PW{1'b0}};
    end else begin
      exp_phase_s = prev_phase_r + PW'(1);
    end
    is_step_s  = dec_legal_s && (dec_phase_s == exp_phase_s);
    is_stall_s = dec_legal_s && (dec_phase_s == prev_phase_r);
  end

  // Tracker state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= SEARCH;
      cnt_r        <= 8'd0;
      prev_phase_r <= {PW{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      prev_phase_r <= prev_phase_nxt_s;
    end
  end

  // Tracker next-state logic; steps update the stored phase so the next +1 is relative to it.
  always_comb begin
    state_nxt_s      = state_r;
    cnt_nxt_s        = cnt_r;
    prev_phase_nxt_s = prev_phase_r;
    err_nxt_s        = 1'b0;
    wrap_nxt_s       = 1'b0;
    if (en) begin
      case (state_r)
        SEARCH: begin
          if (dec_legal_s) begin
            prev_phase_nxt_s = dec_phase_s;
            cnt_nxt_s        = 8'd0;
            state_nxt_s      = TRACK;
          end else begin
            err_nxt_s = 1'b1;
          end
        end
        TRACK: begin
          if (!dec_legal_s) begin
            err_nxt_s   = 1'b1;
            cnt_nxt_s   = 8'd0;
            state_nxt_s = SEARCH;
          end else if (is_step_s) begin
            prev_phase_nxt_s = dec_phase_s;
            cnt_nxt_s        = cnt_r + 8'd1;
            if ((cnt_r + 8'd1) == 8'(LOCK_COUNT)) begin
              state_nxt_s = LOCKED;
            end else begin
              state_nxt_s = TRACK;
            end
          end else if (is_stall_s) begin
            state_nxt_s = TRACK;
          end else begin
            err_nxt_s        = 1'b1;
            prev_phase_nxt_s = dec_phase_s;
            cnt_nxt_s        = 8'd0;
          end
        end
        LOCKED: begin
          if (!dec_legal_s) begin
            err_nxt_s   = 1'b1;
            cnt_nxt_s   = 8'd0;
            state_nxt_s = SEARCH;
          end else if (is_step_s) begin
            prev_phase_nxt_s = dec_phase_s;
            wrap_nxt_s       = (dec_phase_s == {PW{1'b0}});
          end else if (is_stall_s) begin
            state_nxt_s = LOCKED;
          end else begin
            err_nxt_s        = 1'b1;
            prev_phase_nxt_s = dec_phase_s;
            cnt_nxt_s        = 8'd0;
            state_nxt_s      = TRACK;
          end
        end
        default: begin
          cnt_nxt_s   = 8'd0;
          state_nxt_s = SEARCH;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Next values for the registered outputs.
  always_comb begin
    idx_nxt_s       = phase_idx;
    onehot_nxt_s    = phase_onehot;
    valid_nxt_s     = valid_code;
    err_count_nxt_s = err_count;
    if (en) begin
      if (dec_legal_s) begin
        idx_nxt_s    = dec_phase_s;
        onehot_nxt_s = {{(NP-1){1'b0}}, 1'b1} << dec_phase_s;
        valid_nxt_s  = 1'b1;
      end else begin
        onehot_nxt_s = {NP{1'b0}};
        valid_nxt_s  = 1'b0;
      end
    end else begin
      valid_nxt_s = valid_code;
    end
    if (err_nxt_s && (err_count != {ERR_CNT_W{1'b1}})) begin
      err_count_nxt_s = err_count + ERR_CNT_W'(1);
    end else begin
      err_count_nxt_s = err_count;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_idx    <= {PW{1'b0}};
      phase_onehot <= {NP{1'b0}};
      valid_code   <= 1'b0;
      locked       <= 1'b0;
      err_pulse    <= 1'b0;
      wrap_pulse   <= 1'b0;
      err_count    <= {ERR_CNT_W{1'b0}};
    end else begin
      phase_idx    <= idx_nxt_s;
      phase_onehot <= onehot_nxt_s;
      valid_code   <= valid_nxt_s;
      locked       <= (state_nxt_s == LOCKED);
      err_pulse    <= err_nxt_s;
      wrap_pulse   <= wrap_nxt_s;
      err_count    <= err_count_nxt_s;
    end
  end

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Directed bench for johnson_phase_decoder: lock acquisition, wrap, errors, enable hold, saturation.
module tb_johnson_phase_decoder;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] jc_in;
  logic [2:0] phase_idx;
  logic [7:0] phase_onehot;
  logic       valid_code;
  logic       locked;
  logic       err_pulse;
  logic       wrap_pulse;
  logic [7:0] err_count;

  int tests_run;
  int tests_failed;

  johnson_phase_decoder #(.WIDTH(4), .LOCK_COUNT(3), .ERR_CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .jc_in        (jc_in),
    .phase_idx    (phase_idx),
    .phase_onehot (phase_onehot),
    .valid_code   (valid_code),
    .locked       (locked),
    .err_pulse    (err_pulse),
    .wrap_pulse   (wrap_pulse),
    .err_count    (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one sample and wait until just after the capturing edge.
  task automatic apply(input logic e, input logic [3:0] code);
    @(negedge clk);
    en    = e;
    jc_in = code;
    @(posedge clk);
    #1;
  endtask

  // Full output snapshot against expected values.
  task automatic expect_all(input string tag, input logic [2:0] idx, input logic [7:0] oh,
                            input logic v, input logic lk, input logic er, input logic wr,
                            input logic [7:0] ec);
    check({tag, ".idx"},    32'(phase_idx),    32'(idx));
    check({tag, ".onehot"}, 32'(phase_onehot), 32'(oh));
    check({tag, ".valid"},  32'(valid_code),   32'(v));
    check({tag, ".locked"}, 32'(locked),       32'(lk));
    check({tag, ".err"},    32'(err_pulse),    32'(er));
    check({tag, ".wrap"},   32'(wrap_pulse),   32'(wr));
    check({tag, ".errcnt"}, 32'(err_count),    32'(ec));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst   = 1'b1;
    en    = 1'b0;
    jc_in = 4'b0000;
    @(posedge clk);
    #1;
    expect_all("reset", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: acquire lock
    apply(1'b1, 4'b0000); expect_all("acq0", 3'd0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    apply(1'b1, 4'b1000); expect_all("acq1", 3'd1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    apply(1'b1, 4'b1100); expect_all("acq2", 3'd2, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    apply(1'b1, 4'b1110); expect_all("acq3", 3'd3, 8'h08, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);

    // 2: walk to the wrap point while locked
    apply(1'b1, 4'b1111); expect_all("walk4", 3'd4, 8'h10, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    apply(1'b1, 4'b0111); expect_all("walk5", 3'd5, 8'h20, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    apply(1'b1, 4'b0011); expect_all("wrap6", 3'd6, 8'h40, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    apply(1'b1, 4'b0001); expect_all("wrap7", 3'd7, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    apply(1'b1, 4'b0000); expect_all("wrap0", 3'd0, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0);
    apply(1'b1, 4'b1000); expect_all("postwrap", 3'd1, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);

    // 3: illegal code while locked at phase 3
    apply(1'b1, 4'b1100);
    apply(1'b1, 4'b1110); check("pre_ill.locked", 32'(locked), 32'd1);
    apply(1'b1, 4'b1010); expect_all("illegal", 3'd3, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
    apply(1'b1, 4'b0000); expect_all("relk0", 3'd0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    apply(1'b1, 4'b1000);
    apply(1'b1, 4'b1100); check("relk2.locked", 32'(locked), 32'd0);
    apply(1'b1, 4'b1110); expect_all("relk3", 3'd3, 8'h08, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);

    // 4: skipped phase from phase 2
    apply(1'b1, 4'b1111);
    apply(1'b1, 4'b0111);
    apply(1'b1, 4'b0011);
    apply(1'b1, 4'b0001);
    apply(1'b1, 4'b0000);
    apply(1'b1, 4'b1000);
    apply(1'b1, 4'b1100); expect_all("pre_skip", 3'd2, 8'h04, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
    apply(1'b1, 4'b1111); expect_all("skip", 3'd4, 8'h10, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2);
    apply(1'b1, 4'b0111); check("skip5.locked", 32'(locked), 32'd0);
    apply(1'b1, 4'b0011); check("skip6.locked", 32'(locked), 32'd0);
    apply(1'b1, 4'b0001); expect_all("skip_relk", 3'd7, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2);

    // 5: reach phase 5, then enable low and stall
    apply(1'b1, 4'b0000); check("p0.wrap", 32'(wrap_pulse), 32'd1);
    apply(1'b1, 4'b1000);
    apply(1'b1, 4'b1100);
    apply(1'b1, 4'b1110);
    apply(1'b1, 4'b1111);
    apply(1'b1, 4'b0111); expect_all("at5", 3'd5, 8'h20, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2);
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 4'($urandom_range(0, 15)));
      expect_all("en_low", 3'd5, 8'h20, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2);
    end
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 4'b0111);
      expect_all("stall", 3'd5, 8'h20, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2);
    end

    // 6: saturating error count, then reset
    for (int i = 0; i < 300; i++) begin
      apply(1'b1, 4'b0101);
      if (i == 252) check("sat_edge.errcnt", 32'(err_count), 32'd255);
    end
    expect_all("sat", 3'd5, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'd255);
    @(negedge clk);
    rst   = 1'b1;
    en    = 1'b1;
    jc_in = 4'b1000;
    @(posedge clk);
    #1;
    expect_all("rst2", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    apply(1'b1, 4'b1100); expect_all("post_rst", 3'd2, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    apply(1'b1, 4'b0110); expect_all("post_rst_ill", 3'd2, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/johnson_phase_decoder.md
Name: johnson_phase_decoder

Overview:
- Consumes the parallel state of the team's inverted-feedback (twisted-ring) shift counter and decodes it into a binary phase index and a one-hot phase strobe for downstream sequencing logic.
- Checks that every sampled code is a legal Johnson code and that it advances by exactly one phase. Flags errors and maintains a lock indication.
- Sits directly downstream of the 4-bit Johnson counter; its inputs come straight from that counter's register outputs.

Parameters:
- WIDTH, 4, Johnson register width; phase count NP = 2*WIDTH.
- LOCK_COUNT, 3, consecutive legal +1 steps required to assert locked (1..255).
- ERR_CNT_W, 8, width of saturating error counter.
- PW (derived, not overridable): clog2(NP); 3 for defaults.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  sample enable; jc_in is evaluated only on edges where en=1.
- jc_in  in  WIDTH  counter state; bit WIDTH-1 is the inverted-feedback input end.
- phase_idx  out  PW  decoded phase, 0..NP-1.
- phase_onehot  out  NP  one-hot of phase_idx; all zero when the last sample was illegal.
- valid_code  out  1  last sample was a legal code.
- locked  out  1  tracker in LOCKED state.
- err_pulse  out  1  one-cycle strobe on any detected error.
- wrap_pulse  out  1  one-cycle strobe on the step NP-1 -> 0 while locked.
- err_count  out  ERR_CNT_W  saturating count of errors since reset.

Behaviour:
- Legal codes and phase mapping:
  - The counter sequence is 0000 -> 1000 -> 1100 -> 1110 -> 1111 -> 0111 -> 0011 -> 0001 -> 0000.
  - MSB-aligned run of m ones (m = 0..WIDTH) gives phase m.
  - LSB-aligned run of m ones (m = 1..WIDTH-1) gives phase NP-m.
  - Every other code is illegal (2^WIDTH - NP codes; 8 for defaults).
- Latency and registering:
  - All outputs are registered, with 1-cycle latency: the sample taken at edge N is reflected after edge N.
  - With en=0, all registered outputs hold; err_pulse and wrap_pulse are 0.
- Step classification (en=1), relative to the stored previous phase P:
  - Step: new phase = (P+1) mod NP.
  - Stall: new phase = P; no error and no progress.
  - Bad step: any other legal phase.
  - Illegal: the code is not in the legal set.
- State machine (reset state SEARCH); lock counter cnt.
  - SEARCH:
    - Legal code: store phase, cnt=0, go to TRACK.
    - Illegal code: stay in SEARCH and raise err_pulse.
  - TRACK:
    - Step: cnt+1; if cnt+1 = LOCK_COUNT, go to LOCKED.
    - Stall: hold.
    - Bad step: err_pulse; store the new phase, cnt=0, stay in TRACK.
    - Illegal code: err_pulse; go to SEARCH.
  - LOCKED:
    - Step or stall: stay in LOCKED.
    - Bad step: err_pulse; go to TRACK with cnt=0 and the new phase stored.
    - Illegal code: err_pulse; go to SEARCH.
  - locked = (state == LOCKED), registered, so it drops on the same edge err_pulse rises.
- Output update:
  - Legal sample: phase_idx = decoded phase, phase_onehot = 1<<phase, valid_code=1.
  - Illegal sample: phase_idx holds its prior value, phase_onehot=0, valid_code=0.
- wrap_pulse: asserted when the state is LOCKED before the edge, the sample is a step, and the new phase = 0.
- err_count: increments on every err_pulse and saturates at 2^ERR_CNT_W - 1; it does not wrap.
- Reset (synchronous, overrides en):
  - State SEARCH, cnt=0.
  - phase_idx=0, phase_onehot=0, valid_code=0, locked=0, err_pulse=0, wrap_pulse=0, err_count=0.
  - A reset mid-lock clears everything on that edge; the first sample after reset is handled per SEARCH.

Test Plan:
1. Acquire lock:
   - Stimulus: rst, then en=1 and jc_in stepping 0000, 1000, 1100, 1110 on successive edges.
   - Response: valid_code=1 from the first edge; phase_idx 0,1,2,3; phase_onehot 0x01, 0x02, 0x04, 0x08; locked=1 after the 4th edge; err_pulse never asserted.
2. Wrap:
   - Stimulus: while locked, drive 0011, 0001, 0000.
   - Response: phase_idx 6, 7, 0; wrap_pulse=1 only in the cycle after the 0000 sample; locked stays 1.
3. Illegal code:
   - Stimulus: while locked at phase 3, drive 1010.
   - Response: err_pulse=1 for one cycle, err_count=1, locked=0, valid_code=0, phase_onehot=0x00, phase_idx holds 3.
   - Stimulus: then drive 0000, 1000, 1100, 1110.
   - Response: relock after the 4th sample.
4. Skipped phase:
   - Stimulus: while locked at 1100 (phase 2), drive 1111.
   - Response: err_pulse=1, locked=0, valid_code=1, phase_idx=4, phase_onehot=0x10.
   - Stimulus: then three further correct steps.
   - Response: locked=1.
5. Enable and stall:
   - Stimulus: locked at phase 5; hold en=0 for 5 cycles while jc_in is toggled randomly.
   - Response: outputs unchanged, no pulses.
   - Stimulus: en=1 with 0111 repeated 3 times.
   - Response: no error, locked stays 1.
6. Reset and saturation:
   - Stimulus: drive 300 consecutive illegal samples (0101).
   - Response: err_count saturates at 255.
   - Stimulus: assert rst for one edge.
   - Response: err_count=0, all outputs 0, state SEARCH.
